// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch FSM (REQ/WAIT/HOLD)
// Optional delivered-instruction counter is built only with macro IFU_FETCH_CNT_EN.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  input  logic            resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_stale;
  logic            w_stale_nxt;
  logic            w_latch;
  logic [XLEN-1:0] w_redir_pc;
  logic [31:0]     r_out_inst;
  logic [XLEN-1:0] r_out_pc;
  logic            r_out_err;

  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Handshake flags come from the state register alone.
  assign req_valid = (r_state == S_REQ);
  assign out_valid = (r_state == S_HOLD);
  assign req_addr  = r_pc;
  assign out_inst  = r_out_inst;
  assign out_pc    = r_out_pc;
  assign out_err   = r_out_err;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale;
    w_latch     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (req_ready) begin
          w_state_nxt = S_WAIT;
          // Keep a stale mark left by reset so the pre-reset response is dropped.
          w_stale_nxt = r_stale | redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (resp_valid) begin
          if (r_stale || redirect_valid) begin
            w_state_nxt = S_REQ;
            w_stale_nxt = 1'b0;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_stale_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (out_ready) begin
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_stale    <= (r_state == S_WAIT);
      r_out_inst <= 32'd0;
      r_out_pc   <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
      if (w_latch) begin
        r_out_inst <= resp_data;
        r_out_pc   <= r_pc;
        r_out_err  <= resp_err;
      end
    end
  end

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
    end else if (out_valid && out_ready && !redirect_valid) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule
